// File: rtl/sram_wr_serializer.sv
// Write-side front end for a 2W register SRAM: compacts up to four lane writes per
// cycle into an ordered circular queue and drains two per cycle onto registered ports.
// Optional stall counter output enabled by defining SRAM_WR_SERIALIZER_STATS_EN.
module sram_wr_serializer #(
  parameter int SRAM_INDEX  = 4,
  parameter int SRAM_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 8,
  parameter int QUEUE_INDEX = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   we0_i,
  input  logic                   we1_i,
  input  logic                   we2_i,
  input  logic                   we3_i,
  input  logic [SRAM_INDEX-1:0]  addr0_i,
  input  logic [SRAM_INDEX-1:0]  addr1_i,
  input  logic [SRAM_INDEX-1:0]  addr2_i,
  input  logic [SRAM_INDEX-1:0]  addr3_i,
  input  logic [SRAM_WIDTH-1:0]  data0_i,
  input  logic [SRAM_WIDTH-1:0]  data1_i,
  input  logic [SRAM_WIDTH-1:0]  data2_i,
  input  logic [SRAM_WIDTH-1:0]  data3_i,
  output logic [SRAM_INDEX-1:0]  addr0wr_o,
  output logic [SRAM_INDEX-1:0]  addr1wr_o,
  output logic [SRAM_WIDTH-1:0]  data0wr_o,
  output logic [SRAM_WIDTH-1:0]  data1wr_o,
  output logic                   we0_o,
  output logic                   we1_o,
`ifdef SRAM_WR_SERIALIZER_STATS_EN
  output logic [15:0]            stall_cnt_o,
`endif
  output logic [QUEUE_INDEX:0]   count_o
);

  localparam int NUM_LANES = 4;
  localparam int CW        = QUEUE_INDEX + 1;

  typedef struct packed {
    logic [SRAM_INDEX-1:0] addr;
    logic [SRAM_WIDTH-1:0] data;
  } entry_t;

  logic [NUM_LANES-1:0]                 we_l;
  logic [NUM_LANES-1:0][SRAM_INDEX-1:0] addr_l;
  logic [NUM_LANES-1:0][SRAM_WIDTH-1:0] data_l;
  logic [NUM_LANES-1:0][2:0]            off;
  logic [NUM_LANES-1:0][QUEUE_INDEX-1:0] wslot;
  logic [2:0]                           n_in, n_acc;
  logic [1:0]                           n_out;
  logic                                 accept;

  logic [QUEUE_INDEX-1:0] head, tail, head1;
  logic [CW-1:0]          count;
  entry_t                 mem [QUEUE_DEPTH];

  assign we_l   = {we3_i, we2_i, we1_i, we0_i};
  assign addr_l = {addr3_i, addr2_i, addr1_i, addr0_i};
  assign data_l = {data3_i, data2_i, data1_i, data0_i};

  // Compaction: each enabled lane lands at tail + (number of enabled lanes below it).
  always_comb begin
    off[0] = 3'd0;
    for (int i = 1; i < NUM_LANES; i++)
      off[i] = off[i-1] + {2'b0, we_l[i-1]};
  end
  assign n_in = off[NUM_LANES-1] + {2'b0, we_l[NUM_LANES-1]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign wslot[g] = tail + QUEUE_INDEX'(off[g]);
  end

  assign in_ready_o = (count <= CW'(QUEUE_DEPTH - 4)) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign n_acc      = accept ? n_in : 3'd0;
  assign n_out      = (count == '0) ? 2'd0 : (count == CW'(1)) ? 2'd1 : 2'd2;
  assign head1      = head + QUEUE_INDEX'(1);
  assign count_o    = count;

  // Queue storage carries no reset; occupancy is tracked by head/tail/count only.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (accept && we_l[i]) mem[wslot[i]] <= '{addr: addr_l[i], data: data_l[i]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      we0_o     <= 1'b0;
      we1_o     <= 1'b0;
      addr0wr_o <= '0;
      addr1wr_o <= '0;
      data0wr_o <= '0;
      data1wr_o <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      we0_o <= 1'b0;
      we1_o <= 1'b0;
    end else begin
      head  <= head + QUEUE_INDEX'(n_out);
      tail  <= tail + QUEUE_INDEX'(n_acc);
      count <= count + CW'(n_acc) - CW'(n_out);
      we0_o <= (n_out != 2'd0);
      we1_o <= (n_out == 2'd2);
      if (n_out != 2'd0) begin
        addr0wr_o <= mem[head].addr;
        data0wr_o <= mem[head].data;
      end
      // Port 1 always carries the younger entry so later-port-wins keeps order.
      if (n_out == 2'd2) begin
        addr1wr_o <= mem[head1].addr;
        data1wr_o <= mem[head1].data;
      end
    end
  end

`ifdef SRAM_WR_SERIALIZER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       stall_cnt_o <= '0;
    else if (flush_i)                                 stall_cnt_o <= '0;
    else if (in_valid_i && !in_ready_o && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sram_wr_serializer.sv
// Directed self-checking bench for sram_wr_serializer with a 2W SRAM model
// (port 1 written after port 0) and an in-order write collector.
module tb_sram_wr_serializer;
  logic       clk, reset, flush_i, in_valid_i, in_ready_o;
  logic       we0_i, we1_i, we2_i, we3_i;
  logic [3:0] addr0_i, addr1_i, addr2_i, addr3_i;
  logic [7:0] data0_i, data1_i, data2_i, data3_i;
  logic [3:0] addr0wr_o, addr1wr_o;
  logic [7:0] data0wr_o, data1wr_o;
  logic       we0_o, we1_o;
  logic [3:0] count_o;
`ifdef SRAM_WR_SERIALIZER_STATS_EN
  logic [15:0] stall_cnt_o;
`endif

  int n_chk = 0, n_fail = 0;

  sram_wr_serializer dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .we0_i(we0_i), .we1_i(we1_i), .we2_i(we2_i), .we3_i(we3_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .addr2_i(addr2_i), .addr3_i(addr3_i),
    .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i), .data3_i(data3_i),
    .addr0wr_o(addr0wr_o), .addr1wr_o(addr1wr_o), .data0wr_o(data0wr_o), .data1wr_o(data1wr_o),
    .we0_o(we0_o), .we1_o(we1_o),
`ifdef SRAM_WR_SERIALIZER_STATS_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: port 1 written last so it wins on an address collision.
  logic [7:0] sram [16];
  always @(posedge clk) begin
    if (we0_o) sram[addr0wr_o] <= data0wr_o;
    if (we1_o) sram[addr1wr_o] <= data1wr_o;
  end

  // Collector of issued writes in port order, sampled away from the edge.
  logic        mon_en = 1'b0;
  logic [11:0] seen [$];
  always @(negedge clk) if (mon_en) begin
    if (we0_o) seen.push_back({addr0wr_o, data0wr_o});
    if (we1_o) seen.push_back({addr1wr_o, data1wr_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_grp(input logic [3:0] we, input logic [3:0][3:0] a, input logic [3:0][7:0] d);
    in_valid_i = 1'b1;
    {we3_i, we2_i, we1_i, we0_i} = we;
    addr0_i = a[0]; addr1_i = a[1]; addr2_i = a[2]; addr3_i = a[3];
    data0_i = d[0]; data1_i = d[1]; data2_i = d[2]; data3_i = d[3];
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    {we3_i, we2_i, we1_i, we0_i} = 4'b0;
  endtask

  initial begin
    reset = 1'b0; flush_i = 1'b0;
    idle();
    addr0_i = '0; addr1_i = '0; addr2_i = '0; addr3_i = '0;
    data0_i = '0; data1_i = '0; data2_i = '0; data3_i = '0;
    #23;
    chk("rst_count", count_o, 0);
    chk("rst_we", {we1_o, we0_o}, 0);
    chk("rst_addr", {addr1wr_o, addr0wr_o}, 0);
    reset = 1'b1;
    tick();
    chk("rst_ready", in_ready_o, 1);

    // Full group: two output cycles of two writes each.
    set_grp(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, {8'hA4, 8'hA3, 8'hA2, 8'hA1});
    tick(); idle();
    chk("full_count_acc", count_o, 4);
    chk("full_we_lat", {we1_o, we0_o}, 0);
    tick();
    chk("full_p0", {we0_o, addr0wr_o, data0wr_o}, {1'b1, 4'd1, 8'hA1});
    chk("full_p1", {we1_o, addr1wr_o, data1wr_o}, {1'b1, 4'd2, 8'hA2});
    chk("full_count", count_o, 2);
    tick();
    chk("full_p0b", {we0_o, addr0wr_o, data0wr_o}, {1'b1, 4'd3, 8'hA3});
    chk("full_p1b", {we1_o, addr1wr_o, data1wr_o}, {1'b1, 4'd4, 8'hA4});
    tick();
    chk("full_idle", {we1_o, we0_o}, 0);
    chk("full_ready", in_ready_o, 1);

    // Sparse lanes 1 and 3 compact into one output cycle.
    set_grp(4'b1010, {4'd7, 4'd13, 4'd5, 4'd14}, {8'h37, 8'h2D, 8'h15, 8'h0E});
    tick(); idle();
    chk("sparse_count", count_o, 2);
    tick();
    chk("sparse_p0", {we0_o, addr0wr_o, data0wr_o}, {1'b1, 4'd5, 8'h15});
    chk("sparse_p1", {we1_o, addr1wr_o, data1wr_o}, {1'b1, 4'd7, 8'h37});
    tick();
    chk("sparse_idle", {we1_o, we0_o}, 0);

    // Same address in one drain pair: SRAM keeps the younger data.
    set_grp(4'b0011, {4'd0, 4'd0, 4'd9, 4'd9}, {8'd0, 8'd0, 8'd22, 8'd11});
    tick(); idle();
    tick();
    chk("same_p0", {we0_o, addr0wr_o, data0wr_o}, {1'b1, 4'd9, 8'd11});
    chk("same_p1", {we1_o, addr1wr_o, data1wr_o}, {1'b1, 4'd9, 8'd22});
    tick();
    chk("same_sram", sram[9], 22);

    // Back-to-back full groups: producer holds each group until accepted.
    begin
      int g = 0, maxc = 0, stalls = 0, cyc = 0;
      seen.delete();
      mon_en = 1'b1;
      while (g < 6 && cyc < 100) begin
        set_grp(4'b1111,
                {4'(g*4+3), 4'(g*4+2), 4'(g*4+1), 4'(g*4)},
                {8'(g*4+3), 8'(g*4+2), 8'(g*4+1), 8'(g*4)});
        if (int'(count_o) > 4) chk("b2b_ready_low", in_ready_o, 0);
        if (!in_ready_o) stalls++;
        if (in_ready_o) g++;
        tick();
        if (int'(count_o) > maxc) maxc = int'(count_o);
        cyc++;
      end
      idle();
      chk("b2b_all_acc", g, 6);
      for (int i = 0; i < 10; i++) tick();
      mon_en = 1'b0;
      chk("b2b_maxcount", maxc, 6);
      chk("b2b_stalled", stalls > 0, 1);
      chk("b2b_drained", count_o, 0);
      chk("b2b_len", seen.size(), 24);
      for (int i = 0; i < 24 && i < seen.size(); i++)
        chk($sformatf("b2b_order%0d", i), seen[i], {4'(i), 8'(i)});
    end

    // Flush with six entries resident and a valid group offered.
    set_grp(4'b1111, {4'd3, 4'd2, 4'd1, 4'd0}, {8'h13, 8'h12, 8'h11, 8'h10});
    tick();
    set_grp(4'b1111, {4'd7, 4'd6, 4'd5, 4'd4}, {8'h17, 8'h16, 8'h15, 8'h14});
    tick();
    chk("flush_pre_count", count_o, 6);
    set_grp(4'b1111, {4'd11, 4'd10, 4'd9, 4'd8}, {8'h1B, 8'h1A, 8'h19, 8'h18});
    flush_i = 1'b1;
    #1 chk("flush_ready", in_ready_o, 0);
    tick();
    flush_i = 1'b0; idle();
    chk("flush_count", count_o, 0);
    chk("flush_we", {we1_o, we0_o}, 0);
    tick();
    chk("flush_noacc_cnt", count_o, 0);
    chk("flush_noacc_we", {we1_o, we0_o}, 0);

    // Asynchronous reset in the middle of a drain.
    set_grp(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, {8'hB4, 8'hB3, 8'hB2, 8'hB1});
    tick(); idle();
    tick();
    chk("arst_pre_we", {we1_o, we0_o}, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("arst_we", {we1_o, we0_o}, 0);
    chk("arst_count", count_o, 0);
    #3 reset = 1'b1;
    #1 chk("arst_ready", in_ready_o, 1);
    tick();
    chk("arst_idle", {we1_o, we0_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/sram_wr_serializer.md
Name: sram_wr_serializer

Overview:
- Write-side front end for a multi-write-port register SRAM.
- Accepts up to 4 write requests per cycle from producer lanes and buffers them in order in a circular queue.
- Drains at most 2 writes per cycle onto registered SRAM write ports (addr/data/we triples).
- Lets a core with more writers than physical write ports share a cheaper 2W array without losing ordering.

Parameters:
- SRAM_INDEX, 4, address width of the target SRAM.
- SRAM_WIDTH, 8, data width of the target SRAM.
- QUEUE_DEPTH, 8, queue entries; power of two, >= 4.
- QUEUE_INDEX, 3, log2(QUEUE_DEPTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush_i  in  1  synchronous queue discard.
- in_valid_i  in  1  request group valid.
- in_ready_o  out  1  queue can accept a full 4-lane group.
- we0_i..we3_i  in  1 each  lane write enable.
- addr0_i..addr3_i  in  SRAM_INDEX each  lane write address.
- data0_i..data3_i  in  SRAM_WIDTH each  lane write data.
- addr0wr_o, addr1wr_o  out  SRAM_INDEX  SRAM write addresses.
- data0wr_o, data1wr_o  out  SRAM_WIDTH  SRAM write data.
- we0_o, we1_o  out  1  SRAM write enables.
- count_o  out  QUEUE_INDEX+1  current queue occupancy.

Behaviour:
- Reset (reset=0, async): head, tail and count cleared to 0. we0_o, we1_o, addr*wr_o and data*wr_o forced to 0. Queue data storage is not reset. After release, in_ready_o=1.
- in_ready_o is combinational: 1 iff count <= QUEUE_DEPTH-4 and flush_i=0.
- Accept happens when in_valid_i & in_ready_o:
  - Lanes with we*_i=1 are enqueued compacted, in lane order 0->3, starting at tail.
  - n_in = popcount(we0_i..we3_i); n_in=0 is legal and is a no-op.
  - in_valid_i while in_ready_o=0 has no effect. The producer must hold the group.
- Drain, every cycle:
  - n_out = min(count, 2).
  - The oldest entry is registered into port 0 (addr0wr_o/data0wr_o, we0_o=1). The next oldest goes to port 1 when n_out=2.
  - Ports without an entry get we*_o=0; their addr/data hold previous values.
  - Output registers update every edge, so each write is presented for exactly one cycle.
- Port 1 is always younger than port 0. A same-address pair in one cycle relies on the SRAM's later-port-wins rule, which preserves program order.
- Same-cycle enqueue and drain: drain reads the pre-edge queue contents. Next count = count + n_in - n_out, and never exceeds QUEUE_DEPTH.
- Latency: a write accepted at edge k appears on the SRAM ports after edge k+1 when the queue was empty. Otherwise it appears after all older entries have drained, at 2 per cycle.
- Head and tail pointers wrap modulo QUEUE_DEPTH.
- Flush (flush_i=1 at an edge):
  - head, tail and count are cleared; we0_o and we1_o are registered 0.
  - The input group is not accepted that cycle.
  - Flush has priority over accept and drain.
- Empty queue: we0_o=we1_o=0. count=1: only port 0 is written.

Optional Feature:
- Macro: SRAM_WR_SERIALIZER_STATS_EN.
- With the macro defined:
  - Adds output stall_cnt_o (16 bits).
  - It increments, saturating at 0xFFFF, on each cycle with in_valid_i=1 and in_ready_o=0.
  - It clears on reset and on flush_i.
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, then in_valid=1 with we=1111, addr 1/2/3/4, data A1/A2/A3/A4. Required response:
  - Next cycle: port0=(1,A1), port1=(2,A2), count_o=2.
  - Cycle after: port0=(3,A3), port1=(4,A4).
  - Cycle after that: we0_o=we1_o=0.
- Sparse lanes: we=1010 (lanes 1 and 3), addr 5/7. Required: a single output cycle with port0=lane1 (5), port1=lane3 (7); compaction verified.
- Back-to-back full groups every cycle with depth 8 and drain rate 2. Required:
  - in_ready_o drops to 0 when count exceeds 4.
  - Stalled groups are not lost.
  - All writes emerge in order with no duplicates across pointer wrap.
- Same address: lanes 0 and 1 both write addr 9 with data 11 then 22. Required: port0=(9,11) and port1=(9,22) in the same cycle; the SRAM model reads back 22.
- Queue holding 6 entries, then flush_i=1 alongside a valid group. Required: count_o=0 next cycle, no writes issued, and the group is not accepted.
- reset driven low mid-drain, asynchronously between edges. Required: we0_o/we1_o go to 0 immediately, count_o=0, and in_ready_o=1 once reset returns high.
